predict_result_fifo: RTL and testbench
======================================

# predict_result_fifo

Consumer-side companion to the argmax classifier stage in the SoC CNN datapath. It captures each `predict`/`predict_ok` result, checks the class index, and buffers results in a small show-ahead FIFO. The processor or display logic drains the FIFO through a valid/ready read port. Sticky overflow and bad-class flags record lost or illegal results.

## Interface

Parameters:
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥2.
- `dataWidthBCD`, 4: class-index width.
- `NUM_CLASSES`, 10: legal indices are 0..NUM_CLASSES-1.

Ports:
- `clk`  in  1: single clock; all logic on posedge.
- `rst`  in  1: asynchronous, active-low reset.
- `predict`  in  dataWidthBCD: class index from the classifier.
- `predict_ok`  in  1: result-valid level; a capture occurs on its rising edge only.
- `rd_valid`  out  1: `rd_data` holds the oldest entry.
- `rd_data`  out  dataWidthBCD: head entry (show-ahead).
- `rd_ready`  in  1: consumer accepts the head when high together with `rd_valid`.
- `count`  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow`  out  1: sticky; a legal result was dropped because the FIFO was full.
- `bad_class`  out  1: sticky; a result ≥ NUM_CLASSES was seen and discarded.
- `clear_flags`  in  1: synchronous clear of `overflow` and `bad_class` (and histogram, if compiled in).

## Operation

- Edge detect:
  - Register `ok_d <= predict_ok`.
  - `cap = predict_ok & ~ok_d`.
  - A level held high for many cycles yields exactly one capture.
- Class check on `cap`:
  - `predict < NUM_CLASSES` (unsigned compare): push request.
  - Otherwise: set `bad_class` and do not push.
- Storage: circular buffer with `wr_ptr`/`rd_ptr` of width $clog2(DEPTH). Both pointers wrap modulo DEPTH.
- `pop = rd_valid & rd_ready`. `push` = legal capture while not full, or while full with `pop` in the same cycle.
- Simultaneous push and pop:
  - Both pointers advance and `count` is unchanged.
  - When full, the slot freed by the pop receives the push; nothing is lost.
  - When empty, no pop is possible (`rd_valid=0`). The push lands normally.
- Full without pop: the legal capture is dropped and `overflow` is set. The FIFO contents are unchanged.
- `rd_valid = (count != 0)`. `rd_data = mem[rd_ptr]`. Contents are undefined-but-stable when `rd_valid=0`.
- `clear_flags` and a new flag event in the same cycle: the set wins, so the flag reads 1.

## Timing

- Reset (async assert, sync-safe release): `rd_valid=0`, `rd_data=0`, `count=0`, `overflow=0`, `bad_class=0`, `ok_d=0`, pointers 0. Memory contents are not reset.
  - Consequence: if `predict_ok` is already high at reset release, it counts as a rising edge and is captured.
- Capture latency: if `predict_ok` rises before posedge N, the entry is written at N. `rd_valid`/`count` update and are visible after N, i.e. one cycle.
- Pop takes effect at the posedge where `rd_valid & rd_ready`. The next entry, if any, is visible after that edge. Zero-bubble back-to-back reads are supported.
- Flags update on the same edge as the triggering capture.
- Reset mid-operation discards all entries and flags immediately. No partial state survives.

## Configuration

- `PREDICT_HIST_EN` defined:
  - Adds input `hist_sel[dataWidthBCD-1:0]` and output `hist_count[15:0]`.
  - Ten 16-bit counters, one per class. Each legal capture increments its class counter, independent of FIFO full (dropped results are still counted).
  - Counters saturate at 16'hFFFF.
  - `hist_count = counter[hist_sel]`. It reads 0 if `hist_sel ≥ NUM_CLASSES`.
  - Counters reset to 0 and are cleared by `clear_flags`.
- Not defined: the ports are absent, with no histogram logic.

## Test plan

- Single result: `predict=7`, `predict_ok` pulses high for 3 cycles, `rd_ready=0` -> exactly one entry. `count=1`, `rd_valid=1`, `rd_data=7` one cycle after the rising edge.
- Ordering and wrap: push 0..9 with `DEPTH=8` and `rd_ready=1` throughout -> reads 0..9 in order, pointers wrap, `overflow=0`.
- Overflow: `rd_ready=0`, 9 legal captures (values 1..9) -> `count=8`, `overflow=1`, drained sequence 1..8.
- Full with simultaneous pop and push: FIFO full, `rd_ready=1` on the capture cycle with `predict=5` -> `count` stays 8, `overflow=0`, and 5 appears as the last entry.
- Bad class: `predict=12` edge -> `bad_class=1`, `count` unchanged. Then `clear_flags` for one cycle -> `bad_class=0`. A capture with `predict=13` coinciding with `clear_flags` -> `bad_class=1`.
- Async reset with `count=4`: assert `rst=0` between clock edges -> outputs clear immediately (`count=0`, `rd_valid=0`). With `PREDICT_HIST_EN`, 3 captures of class 2 give `hist_sel=2` -> `hist_count=3`.

Source files
------------

// File: rtl/predict_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : predict_result_fifo
// Captures classifier results on predict_ok rising edges, rejects illegal
// class indices and buffers legal ones in a show-ahead FIFO with sticky
// overflow/bad-class flags. Optional per-class histogram: PREDICT_HIST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module predict_result_fifo #(
    parameter int DEPTH        = 8,
    parameter int dataWidthBCD = 4,
    parameter int NUM_CLASSES  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [dataWidthBCD-1:0]   predict,
    input  logic                      predict_ok,
    output logic                      rd_valid,
    output logic [dataWidthBCD-1:0]   rd_data,
    input  logic                      rd_ready,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      bad_class,
    input  logic                      clear_flags
`ifdef PREDICT_HIST_EN
    ,
    input  logic [dataWidthBCD-1:0]   hist_sel,
    output logic [15:0]               hist_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    ok_prev_q;
    logic                    overflow_q, overflow_d;
    logic                    bad_class_q, bad_class_d;
    logic [dataWidthBCD-1:0] mem_q [DEPTH];

    logic cap, legal, full, pop, push;

    always_comb begin
        cap   = predict_ok & ~ok_prev_q;
        legal = 32'(predict) < 32'(NUM_CLASSES);
        full  = (count_q == CW'(DEPTH));
        pop   = rd_valid & rd_ready;
        // When full, a same-cycle pop frees the slot the push lands in.
        push  = cap & legal & (~full | pop);

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A flag event in the same cycle as clear_flags wins.
        overflow_d = clear_flags ? 1'b0 : overflow_q;
        if (cap && legal && full && !pop) begin
            overflow_d = 1'b1;
        end
        bad_class_d = clear_flags ? 1'b0 : bad_class_q;
        if (cap && !legal) begin
            bad_class_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ok_prev_q   <= 1'b0;
            overflow_q  <= 1'b0;
            bad_class_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ok_prev_q   <= predict_ok;
            overflow_q  <= overflow_d;
            bad_class_q <= bad_class_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= predict;
        end
    end

    assign rd_valid  = (count_q != '0);
    assign rd_data   = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign bad_class = bad_class_q;

`ifdef PREDICT_HIST_EN
    logic [15:0] hist_q [NUM_CLASSES];
    logic [15:0] hist_d [NUM_CLASSES];
    logic [15:0] hist_base;

    // Dropped results are still counted; counters saturate.
    always_comb begin
        hist_base = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            hist_base = clear_flags ? 16'd0 : hist_q[i];
            hist_d[i] = hist_base;
            if (cap && legal && (32'(predict) == 32'(i)) && (hist_base != 16'hFFFF)) begin
                hist_d[i] = hist_base + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    always_comb begin
        hist_count = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (32'(hist_sel) == 32'(i)) begin
                hist_count = hist_q[i];
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_predict_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_predict_result_fifo
// Directed vector table plus hand-written sequences for predict_result_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_predict_result_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] predict = '0;
    logic       predict_ok = 1'b0;
    logic       rd_valid;
    logic [3:0] rd_data;
    logic       rd_ready = 1'b0;
    logic [3:0] count;
    logic       overflow;
    logic       bad_class;
    logic       clear_flags = 1'b0;
`ifdef PREDICT_HIST_EN
    logic [3:0]  hist_sel = '0;
    logic [15:0] hist_count;
`endif

    int total = 0;
    int bad   = 0;

    predict_result_fifo #(
        .DEPTH(8), .dataWidthBCD(4), .NUM_CLASSES(10)
    ) dut (
        .clk(clk), .rst(rst), .predict(predict), .predict_ok(predict_ok),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .count(count), .overflow(overflow), .bad_class(bad_class),
        .clear_flags(clear_flags)
`ifdef PREDICT_HIST_EN
        , .hist_sel(hist_sel), .hist_count(hist_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] p;
        logic       ok;
        logic       rr;
        logic       cl;
        logic       ev;
        logic [3:0] ed;
        logic [3:0] ec;
        logic       eo;
        logic       eb;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [3:0] v);
        predict    = v;
        predict_ok = 1'b1;
        step();
        predict_ok = 1'b0;
        step();
    endtask

    task automatic clear_all();
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
    endtask

    initial begin
        // p  ok rr cl | valid data count ovf bad
        vecs[0] = '{4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
        vecs[1] = '{4'd7,  1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 4'd1, 1'b0, 1'b0};
        vecs[2] = '{4'd7,  1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 4'd1, 1'b0, 1'b0};
        vecs[3] = '{4'd7,  1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 4'd1, 1'b0, 1'b0};
        vecs[4] = '{4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 4'd1, 1'b0, 1'b0};
        vecs[5] = '{4'd12, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 4'd1, 1'b0, 1'b1};
        vecs[6] = '{4'd12, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 4'd1, 1'b0, 1'b0};
        vecs[7] = '{4'd13, 1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 4'd1, 1'b0, 1'b1};
        vecs[8] = '{4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1};
        vecs[9] = '{4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};

        #12;
        check("reset_count", 32'(count), 32'd0);
        check("reset_valid", 32'(rd_valid), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            predict     = vecs[i].p;
            predict_ok  = vecs[i].ok;
            rd_ready    = vecs[i].rr;
            clear_flags = vecs[i].cl;
            step();
            check($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].ev));
            if (vecs[i].ev) check($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vecs[i].ed));
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].ec));
            check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].eo));
            check($sformatf("vec%0d_bad", i), 32'(bad_class), 32'(vecs[i].eb));
        end
        predict_ok  = 1'b0;
        clear_flags = 1'b0;
        rd_ready    = 1'b0;

        // Ordering and wrap with the consumer always ready.
        rd_ready = 1'b1;
        for (int v = 0; v < 10; v++) begin
            predict    = 4'(v);
            predict_ok = 1'b1;
            step();
            check($sformatf("order_head%0d", v), 32'(rd_data), 32'(v));
            check($sformatf("order_cnt%0d", v), 32'(count), 32'd1);
            predict_ok = 1'b0;
            step();
            check($sformatf("order_drain%0d", v), 32'(count), 32'd0);
        end
        check("order_ovf", 32'(overflow), 32'd0);
        rd_ready = 1'b0;

        // Overflow: nine captures into eight slots.
        for (int v = 1; v <= 9; v++) capture(4'(v));
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        rd_ready = 1'b1;
        for (int v = 1; v <= 8; v++) begin
            check($sformatf("ovf_drain%0d", v), 32'(rd_data), 32'(v));
            step();
        end
        rd_ready = 1'b0;
        check("ovf_empty", 32'(count), 32'd0);
        clear_all();
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Full with simultaneous pop and push.
        for (int v = 1; v <= 8; v++) capture(4'(v));
        check("fullpp_pre", 32'(count), 32'd8);
        predict    = 4'd5;
        predict_ok = 1'b1;
        rd_ready   = 1'b1;
        step();
        predict_ok = 1'b0;
        rd_ready   = 1'b0;
        check("fullpp_count", 32'(count), 32'd8);
        check("fullpp_ovf", 32'(overflow), 32'd0);
        step();
        rd_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            automatic int e = (k < 7) ? k + 2 : 5;
            check($sformatf("fullpp_drain%0d", k), 32'(rd_data), 32'(e));
            step();
        end
        rd_ready = 1'b0;
        check("fullpp_empty", 32'(count), 32'd0);

        // Asynchronous reset mid-operation.
        for (int v = 1; v <= 4; v++) capture(4'(v));
        check("arst_pre", 32'(count), 32'd4);
        #2 rst = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_valid", 32'(rd_valid), 32'd0);
        check("arst_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("arst_after", 32'(count), 32'd0);

`ifdef PREDICT_HIST_EN
        for (int k = 0; k < 3; k++) capture(4'd2);
        hist_sel = 4'd2;
        #1;
        check("hist_cls2", 32'(hist_count), 32'd3);
        hist_sel = 4'd12;
        #1;
        check("hist_illegal_sel", 32'(hist_count), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
